tmds_decoder: RTL

TMDS_DECODER -- requirements
Module: tmds_decoder

---
 rtl/tmds_decoder_pkg.sv | 17 +
 rtl/tmds_channel_align.sv | 102 ++++++++++
 rtl/tmds_decoder.sv | 107 ++++++++++
 3 files changed

// File: rtl/tmds_decoder_pkg.sv
// Shared constants for the TMDS receive path: symbol width, the four control
// tokens (bit 0 is the earliest serial bit) and the per-channel lock states.
package tmds_decoder_pkg;

  localparam int unsigned SymW = 10;

  localparam logic [SymW-1:0] TokC00 = 10'b1101010100;
  localparam logic [SymW-1:0] TokC01 = 10'b0010101011;
  localparam logic [SymW-1:0] TokC10 = 10'b0101010100;
  localparam logic [SymW-1:0] TokC11 = 10'b1010101011;

  typedef enum logic {
    StSearch,
    StLocked
  } chan_state_e;

endpackage

// File: rtl/tmds_channel_align.sv
// One TMDS lane: word-boundary search, control-token detection and the
// SEARCH/LOCKED state machine. Emits the registered aligned symbol.
module tmds_channel_align
  import tmds_decoder_pkg::*;
#(
  parameter int unsigned CTRL_RUN     = 8,
  parameter int unsigned SLIP_TIMEOUT = 64,
  parameter int unsigned LOSS_TIMEOUT = 2048
) (
  input  logic            clk_vga,
  input  logic            rst_n,
  input  logic [SymW-1:0] word,
  output logic [SymW-1:0] sym,
  output logic            sym_ctrl,
  output logic [1:0]      sym_c,
  output logic            chan_locked
);

  localparam int unsigned RunW  = $clog2(CTRL_RUN + 1);
  localparam int unsigned SlipW = $clog2(SLIP_TIMEOUT + 1);
  localparam int unsigned LossW = $clog2(LOSS_TIMEOUT + 1);

  chan_state_e       state_q;
  logic [SymW-1:0]   prev_q;
  logic [3:0]        offset_q;
  logic [RunW-1:0]   run_q;
  logic [SlipW-1:0]  slip_q;
  logic [LossW-1:0]  loss_q;

  logic [2*SymW-1:0] shifted;
  logic [SymW-1:0]   aligned;
  logic              is_ctrl;
  logic [1:0]        ctrl_c;

  // Previous word occupies the low half, so offset 0 selects it whole.
  assign shifted = {word, prev_q} >> offset_q;
  assign aligned = shifted[SymW-1:0];

  always_comb begin
    is_ctrl = 1'b1;
    ctrl_c  = 2'b00;
    case (aligned)
      TokC00:  ctrl_c = 2'b00;
      TokC01:  ctrl_c = 2'b01;
      TokC10:  ctrl_c = 2'b10;
      TokC11:  ctrl_c = 2'b11;
      default: is_ctrl = 1'b0;
    endcase
  end

  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StSearch;
      prev_q   <= '0;
      offset_q <= '0;
      run_q    <= '0;
      slip_q   <= '0;
      loss_q   <= '0;
      sym      <= '0;
      sym_ctrl <= 1'b0;
      sym_c    <= 2'b00;
    end else begin
      prev_q   <= word;
      sym      <= aligned;
      sym_ctrl <= is_ctrl;
      sym_c    <= ctrl_c;
      case (state_q)
        StSearch: begin
          if (is_ctrl && run_q == RunW'(CTRL_RUN - 1)) begin
            state_q <= StLocked;
            run_q   <= '0;
            slip_q  <= '0;
            loss_q  <= '0;
          end else if (slip_q == SlipW'(SLIP_TIMEOUT - 1)) begin
            offset_q <= (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;
            run_q    <= '0;
            slip_q   <= '0;
          end else begin
            slip_q <= slip_q + 1'b1;
            run_q  <= is_ctrl ? run_q + 1'b1 : '0;
          end
        end
        StLocked: begin
          if (is_ctrl) begin
            loss_q <= '0;
          end else if (loss_q == LossW'(LOSS_TIMEOUT - 1)) begin
            state_q <= StSearch;
            loss_q  <= '0;
            run_q   <= '0;
            slip_q  <= '0;
          end else begin
            loss_q <= loss_q + 1'b1;
          end
        end
        default: state_q <= StSearch;
      endcase
    end
  end

  assign chan_locked = (state_q == StLocked);

endmodule

// File: rtl/tmds_decoder.sv
// Three-lane TMDS receiver: per-lane alignment, TMDS data decode and the
// registered pixel/sync/blank/frame_start outputs.
module tmds_decoder
  import tmds_decoder_pkg::*;
#(
  parameter int unsigned CTRL_RUN     = 8,
  parameter int unsigned SLIP_TIMEOUT = 64,
  parameter int unsigned LOSS_TIMEOUT = 2048
) (
  input  logic            clk_vga,
  input  logic            rst_n,
  input  logic [SymW-1:0] tmds_word_r,
  input  logic [SymW-1:0] tmds_word_g,
  input  logic [SymW-1:0] tmds_word_b,
  output logic [7:0]      red,
  output logic [7:0]      green,
  output logic [7:0]      blue,
  output logic            hsync,
  output logic            vsync,
  output logic            blank,
  output logic            locked,
  output logic            frame_start
);

  logic [SymW-1:0] words [3];
  logic [SymW-1:0] syms  [3];
  logic [1:0]      cs    [3];
  logic [2:0]      ctrls;
  logic [2:0]      chan_locked;
  logic            all_locked;
  logic            armed_q;
  logic            unused_rg_ctrl;

  assign words[0] = tmds_word_r;
  assign words[1] = tmds_word_g;
  assign words[2] = tmds_word_b;

  for (genvar i = 0; i < 3; i++) begin : g_chan
    tmds_channel_align #(
      .CTRL_RUN    (CTRL_RUN),
      .SLIP_TIMEOUT(SLIP_TIMEOUT),
      .LOSS_TIMEOUT(LOSS_TIMEOUT)
    ) u_align (
      .clk_vga    (clk_vga),
      .rst_n      (rst_n),
      .word       (words[i]),
      .sym        (syms[i]),
      .sym_ctrl   (ctrls[i]),
      .sym_c      (cs[i]),
      .chan_locked(chan_locked[i])
    );
  end

  // Red/green tokens only matter for their own lock state.
  assign unused_rg_ctrl = ^{ctrls[1:0], cs[0], cs[1]};
  assign all_locked     = &chan_locked;

  function automatic logic [7:0] decode(input logic [SymW-1:0] q);
    logic [7:0] v;
    v = q[9] ? ~q[7:0] : q[7:0];
    return v ^ {v[6:0], 1'b0} ^ {{7{~q[8]}}, 1'b0};
  endfunction

  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      red         <= '0;
      green       <= '0;
      blue        <= '0;
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      blank       <= 1'b1;
      locked      <= 1'b0;
      frame_start <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      locked <= all_locked;
      if (!all_locked) begin
        red         <= '0;
        green       <= '0;
        blue        <= '0;
        hsync       <= 1'b0;
        vsync       <= 1'b0;
        blank       <= 1'b1;
        frame_start <= 1'b0;
        armed_q     <= 1'b0;
      end else if (ctrls[2]) begin
        red         <= '0;
        green       <= '0;
        blue        <= '0;
        hsync       <= cs[2][0];
        vsync       <= cs[2][1];
        blank       <= 1'b1;
        frame_start <= 1'b0;
        if (vsync && !cs[2][1]) armed_q <= 1'b1;
      end else begin
        red         <= decode(syms[0]);
        green       <= decode(syms[1]);
        blue        <= decode(syms[2]);
        blank       <= 1'b0;
        // Fire once on the first active pixel after the vsync falling edge.
        frame_start <= armed_q && blank;
        if (blank) armed_q <= 1'b0;
      end
    end
  end

endmodule
